clock_gater_icg: RTL and testbench

CLOCK_GATER_ICG -- requirements
Module: clock_gater_icg

---
 rtl/clock_gater_icg.sv | 51 +++++
 tb/tb_clock_gater_icg.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_gater_icg.sv
// ---------------------------------------------------------------------------
// clock_gater_icg
//
// Latch-based integrated clock gate. A single enable latch is transparent
// while clock_in is low and holds while clock_in is high. The gated clock is
// the AND of clock_in and the latched enable. Because the latch is closed for
// the whole high phase, clock_out can only ever carry complete clock_in high
// pulses, so it is glitch-free.
//
// Ports
//   clock_in     in  1  source clock, any period and duty cycle
//   reset        in  1  synchronous active-high reset; it reaches the output
//                       only through the enable latch, so it is effectively
//                       sampled at the rising edge of clock_in
//   enable       in  1  functional clock enable, may change at any time
//   test_enable  in  1  scan/test override, ORed with enable
//   clock_out    out 1  gated copy of clock_in, low whenever gated
// ---------------------------------------------------------------------------
module clock_gater_icg (
    input  logic clock_in,
    input  logic reset,
    input  logic enable,
    input  logic test_enable,
    output logic clock_out
);

    logic en_eff;
    logic latched_enable;

    // Reset is folded into the latch input rather than acting on the latch
    // directly. A pulse already in progress therefore completes in full, and
    // the output goes low from the first rising edge after reset was seen
    // during a low phase.
    assign en_eff = (enable | test_enable) & ~reset;

    // Transparent while clock_in is low, closed while it is high. Any enable
    // change during the high phase is held off until after the next falling
    // edge. With clock_in low and all inputs low at time zero, the latch
    // already follows en_eff and reads 0, so clock_out starts low before the
    // first reset.
    always_latch begin
        if (!clock_in) begin
            latched_enable <= en_eff;
        end
    end

    // Pure combinational gating: no register or delay between clock_in and
    // clock_out, so phase and duty cycle are preserved when enabled.
    assign clock_out = clock_in & latched_enable;

endmodule

// File: tb/tb_clock_gater_icg.sv
`timescale 1ns/1ps
module tb_clock_gater_icg;

    logic clock_in    = 1'b0;
    logic reset       = 1'b0;
    logic enable      = 1'b0;
    logic test_enable = 1'b0;
    logic clock_out;

    int checks   = 0;
    int failures = 0;

    // One expected clock_out level per clock_in high phase, pushed when the
    // enable inputs are driven and popped 1 ns into the following high phase.
    logic exp_q[$];
    logic e;

    // clock_out edge monitor
    int      rise_cnt    = 0;
    int      bad_high    = 0;
    int      bad_low     = 0;
    realtime t_rise      = 0.0;
    realtime t_fall      = -100.0;
    realtime prev_rise   = -100.0;
    realtime last_period = 0.0;

    clock_gater_icg dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .enable      (enable),
        .test_enable (test_enable),
        .clock_out   (clock_out)
    );

    // 10 ns period, 50% duty; rising edges at 5, 15, 25 ...
    always #5 clock_in = ~clock_in;

    always @(posedge clock_out) begin
        rise_cnt++;
        last_period = $realtime - prev_rise;
        prev_rise   = $realtime;
        t_rise      = $realtime;
        if ($realtime - t_fall < 4.999) bad_low++;
    end

    always @(negedge clock_out) begin
        t_fall = $realtime;
        if (($realtime - t_rise > 5.001) || ($realtime - t_rise < 4.999)) bad_high++;
    end

    // Reference model of the level the latch will hold at the next rising edge.
    function automatic logic model_en();
        return (enable | test_enable) & ~reset;
    endfunction

    task automatic test_reset();
        int r0;
        #1;
        checks++;
        if (clock_out !== 1'b0) begin
            failures++;
            $display("FAIL init_low: clock_out=%b expected=0", clock_out);
        end
        reset = 1'b1; enable = 1'b1; test_enable = 1'b1;
        exp_q.push_back(model_en());
        r0 = rise_cnt;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (clock_out !== e) begin
                failures++;
                $display("FAIL reset_hold[%0d]: clock_out=%b expected=%b", i, clock_out, e);
            end
            if (i == 2) begin
                reset = 1'b0; enable = 1'b0; test_enable = 1'b0;
            end
            exp_q.push_back(model_en());
        end
        checks++;
        if (rise_cnt - r0 != 0) begin
            failures++;
            $display("FAIL reset_no_edges: rises=%0d expected=0", rise_cnt - r0);
        end
    endtask

    task automatic test_idle();
        int r0;
        r0 = rise_cnt;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (clock_out !== e) begin
                failures++;
                $display("FAIL idle[%0d]: clock_out=%b expected=%b", i, clock_out, e);
            end
            exp_q.push_back(model_en());
        end
        checks++;
        if (rise_cnt - r0 != 0) begin
            failures++;
            $display("FAIL idle_edges: rises=%0d expected=0", rise_cnt - r0);
        end
    endtask

    // use_test selects which input carries the enable sequence.
    task automatic test_enable_path(input bit use_test);
        int r0;
        int r1;
        @(posedge clock_in); #1;
        e = exp_q.pop_front();
        checks++;
        if (clock_out !== e) begin
            failures++;
            $display("FAIL en_start[%0d]: clock_out=%b expected=%b", use_test, clock_out, e);
        end
        if (use_test) test_enable = 1'b1; else enable = 1'b1;
        exp_q.push_back(model_en());
        r0 = rise_cnt;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (clock_out !== e) begin
                failures++;
                $display("FAIL en_run[%0d][%0d]: clock_out=%b expected=%b", use_test, i, clock_out, e);
            end
            if (i == 9) begin
                enable = 1'b0; test_enable = 1'b0;
            end
            exp_q.push_back(model_en());
        end
        checks++;
        if (rise_cnt - r0 != 10) begin
            failures++;
            $display("FAIL en_rises[%0d]: rises=%0d expected=10", use_test, rise_cnt - r0);
        end
        checks++;
        if (int'(last_period) != 10) begin
            failures++;
            $display("FAIL en_period[%0d]: period=%0.3f expected=10", use_test, last_period);
        end
        #5;
        checks++;
        if (clock_out !== 1'b0) begin
            failures++;
            $display("FAIL en_low_phase[%0d]: clock_out=%b expected=0", use_test, clock_out);
        end
        r1 = rise_cnt;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (clock_out !== e) begin
                failures++;
                $display("FAIL en_off[%0d][%0d]: clock_out=%b expected=%b", use_test, i, clock_out, e);
            end
            exp_q.push_back(model_en());
        end
        checks++;
        if (rise_cnt - r1 != 0) begin
            failures++;
            $display("FAIL en_off_edges[%0d]: rises=%0d expected=0", use_test, rise_cnt - r1);
        end
    endtask

    task automatic test_toggle();
        int r0;
        int bh0;
        r0  = rise_cnt;
        bh0 = bad_high;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (clock_out !== e) begin
                failures++;
                $display("FAIL toggle[%0d]: clock_out=%b expected=%b", i, clock_out, e);
            end
            enable = ~enable;
            exp_q.push_back(model_en());
        end
        checks++;
        if (rise_cnt - r0 != 100) begin
            failures++;
            $display("FAIL toggle_rises: rises=%0d expected=100", rise_cnt - r0);
        end
        checks++;
        if (int'(last_period) != 20) begin
            failures++;
            $display("FAIL toggle_period: period=%0.3f expected=20", last_period);
        end
        checks++;
        if (bad_high != bh0) begin
            failures++;
            $display("FAIL toggle_pulse: bad_high_pulses=%0d expected=0", bad_high - bh0);
        end
    endtask

    task automatic test_random_offsets();
        int r0;
        int bh0;
        int bl0;
        int off;
        r0  = rise_cnt;
        bh0 = bad_high;
        bl0 = bad_low;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clock_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (clock_out !== e) begin
                failures++;
                $display("FAIL random[%0d]: clock_out=%b expected=%b", i, clock_out, e);
            end
            off = $urandom_range(9, 1);
            if (off > 1) #(off - 1);
            enable = ~enable;
            exp_q.push_back(model_en());
        end
        checks++;
        if (rise_cnt - r0 != 500) begin
            failures++;
            $display("FAIL random_rises: rises=%0d expected=500", rise_cnt - r0);
        end
        checks++;
        if (bad_high != bh0) begin
            failures++;
            $display("FAIL random_high_pulse: bad=%0d expected=0", bad_high - bh0);
        end
        checks++;
        if (bad_low != bl0) begin
            failures++;
            $display("FAIL random_low_pulse: bad=%0d expected=0", bad_low - bl0);
        end
    endtask

    // Both enables high, then reset overrides them for three cycles.
    task automatic test_reset_override();
        int r0;
        @(posedge clock_in); #1;
        e = exp_q.pop_front();
        checks++;
        if (clock_out !== e) begin
            failures++;
            $display("FAIL rst_ov_start: clock_out=%b expected=%b", clock_out, e);
        end
        enable = 1'b1; test_enable = 1'b1;
        exp_q.push_back(model_en());
        for (int i = 0; i < 4; i++) begin
            @(posedge clock_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (clock_out !== e) begin
                failures++;
                $display("FAIL both_run[%0d]: clock_out=%b expected=%b", i, clock_out, e);
            end
            if (i == 3) reset = 1'b1;
            exp_q.push_back(model_en());
        end
        checks++;
        if (int'(last_period) != 10) begin
            failures++;
            $display("FAIL both_period: period=%0.3f expected=10", last_period);
        end
        r0 = rise_cnt;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (clock_out !== e) begin
                failures++;
                $display("FAIL rst_ov_hold[%0d]: clock_out=%b expected=%b", i, clock_out, e);
            end
            if (i == 2) reset = 1'b0;
            exp_q.push_back(model_en());
        end
        checks++;
        if (rise_cnt - r0 != 0) begin
            failures++;
            $display("FAIL rst_ov_edges: rises=%0d expected=0", rise_cnt - r0);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock_in); #1;
            e = exp_q.pop_front();
            checks++;
            if (clock_out !== e) begin
                failures++;
                $display("FAIL rst_ov_resume[%0d]: clock_out=%b expected=%b", i, clock_out, e);
            end
            if (i == 3) begin
                enable = 1'b0; test_enable = 1'b0;
            end
            exp_q.push_back(model_en());
        end
        @(posedge clock_in); #1;
        e = exp_q.pop_front();
        checks++;
        if (clock_out !== e) begin
            failures++;
            $display("FAIL rst_ov_drain: clock_out=%b expected=%b", clock_out, e);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle();
        test_enable_path(1'b0);
        test_enable_path(1'b1);
        test_toggle();
        test_random_offsets();
        test_reset_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
